// File: rtl/router_port_pkg.sv
// Shared types and link constants for the router-side node link endpoint.
// Packets are 32 bits wide and move over the link as 4 bytes, MSB first.
package router_port_pkg;

  typedef logic [31:0] pkt_t;

  localparam int PKT_BYTES = 4;

  typedef enum logic {
    R_IDLE,
    R_RECV
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_WAIT,
    T_SEND,
    T_GAP
  } tx_state_e;

  function automatic logic [7:0] pkt_byte(
    input pkt_t       p,
    input logic [1:0] idx
  );
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = p[31:24];
      2'd1:    b = p[23:16];
      2'd2:    b = p[15:8];
      default: b = p[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/router_port_if.sv
// Node link and router-core signals of one router port.
// master = node/core side, slave = router_port.
interface router_port_if;
  import router_port_pkg::*;

  logic       put_outbound;
  logic [7:0] payload_outbound;
  logic       free_outbound;

  logic       put_inbound;
  logic [7:0] payload_inbound;
  logic       free_inbound;

  pkt_t       rx_pkt;
  logic       rx_avail;
  logic       rx_take;

  pkt_t       tx_pkt;
  logic       tx_valid;
  logic       tx_ready;

  logic       proto_err;

  modport master (
    output put_outbound,
    output payload_outbound,
    output free_inbound,
    output rx_take,
    output tx_pkt,
    output tx_valid,
    input  free_outbound,
    input  put_inbound,
    input  payload_inbound,
    input  rx_pkt,
    input  rx_avail,
    input  tx_ready,
    input  proto_err
  );

  modport slave (
    input  put_outbound,
    input  payload_outbound,
    input  free_inbound,
    input  rx_take,
    input  tx_pkt,
    input  tx_valid,
    output free_outbound,
    output put_inbound,
    output payload_inbound,
    output rx_pkt,
    output rx_avail,
    output tx_ready,
    output proto_err
  );

endinterface

// File: rtl/router_port_pkt_fifo.sv
// Circular packet buffer, power-of-two depth, sync reset.
// Head is read combinationally and forced to zero while empty.
module pkt_fifo
  import router_port_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_b_i,
  input  logic                     push_i,
  input  pkt_t                     data_i,
  input  logic                     pop_i,
  output pkt_t                     head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pkt_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/router_port.sv
// Router-side link endpoint: deserializes node packets into a receive
// buffer and serializes core packets back to the node.
module router_port
  import router_port_pkg::*;
#(
  parameter int RX_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_b,
  router_port_if.slave  bus
);

  localparam int CW = $clog2(RX_DEPTH) + 1;
  localparam logic [1:0] LAST = 2'(PKT_BYTES - 1);

  rx_state_e     r_q, r_d;
  logic [1:0]    cnt_q, cnt_d;
  pkt_t          asm_q, asm_d;
  logic          err_q, err_d;
  logic          free_out;
  logic          push;
  pkt_t          push_pkt;
  pkt_t          head;
  logic [CW-1:0] rx_count;

  tx_state_e     t_q, t_d;
  logic [1:0]    idx_q, idx_d;
  pkt_t          buf_q, buf_d;
  logic          send;

  pkt_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_b_i (rst_b),
    .push_i  (push),
    .data_i  (push_pkt),
    .pop_i   (bus.rx_take),
    .head_o  (head),
    .count_o (rx_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_q   <= R_IDLE;
      cnt_q <= '0;
      asm_q <= '0;
      err_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    r_d   = r_q;
    cnt_d = cnt_q;
    asm_d = asm_q;
    err_d = err_q;
    unique case (r_q)
      R_IDLE: begin
        if (bus.put_outbound && free_out) begin
          asm_d = {asm_q[23:0], bus.payload_outbound};
          cnt_d = 2'd1;
          r_d   = R_RECV;
        end else if (bus.put_outbound) begin
          err_d = 1'b1;
        end
      end
      R_RECV: begin
        if (bus.put_outbound) begin
          asm_d = {asm_q[23:0], bus.payload_outbound};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST) r_d = R_IDLE;
        end else begin
          // A gap mid-packet drops the partial packet.
          err_d = 1'b1;
          cnt_d = '0;
          r_d   = R_IDLE;
        end
      end
      default: r_d = R_IDLE;
    endcase
  end

  always_comb begin
    free_out = (r_q == R_IDLE) && (rx_count < CW'(RX_DEPTH));
    push     = (r_q == R_RECV) && bus.put_outbound && (cnt_q == LAST);
    push_pkt = {asm_q[23:0], bus.payload_outbound};
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      t_q   <= T_IDLE;
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      t_q   <= t_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  always_comb begin
    t_d   = t_q;
    idx_d = idx_q;
    buf_d = buf_q;
    unique case (t_q)
      T_IDLE: begin
        if (bus.tx_valid) begin
          buf_d = bus.tx_pkt;
          t_d   = T_WAIT;
        end
      end
      T_WAIT: begin
        if (bus.free_inbound) begin
          idx_d = '0;
          t_d   = T_SEND;
        end
      end
      T_SEND: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == LAST) t_d = T_GAP;
      end
      default: t_d = T_IDLE;
    endcase
  end

  always_comb begin
    send = (t_q == T_SEND);
  end

  assign bus.free_outbound   = free_out;
  assign bus.rx_pkt          = head;
  assign bus.rx_avail        = (rx_count != '0);
  assign bus.proto_err       = err_q;
  assign bus.tx_ready        = (t_q == T_IDLE);
  assign bus.put_inbound     = send;
  assign bus.payload_inbound = send ? pkt_byte(buf_q, idx_q) : 8'h00;

endmodule

// File: tb/tb_router_port.sv
// Scoreboarded bench for router_port: directed link scenarios, then
// randomized node/core traffic against a queue-based packet model.
module tb_router_port;
  import router_port_pkg::*;

  localparam int RX_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_b = 1'b0;

  router_port_if bus();

  router_port #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;
  pkt_t       exp_rx[$];
  logic [7:0] exp_tx[$];
  bit         pend = 1'b0;
  pkt_t       pend_pkt;
  int         rk = 0;
  pkt_t       rp;
  bit         fprev = 1'b0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    if (pend) begin
      exp_rx.push_back(pend_pkt);
      pend = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rx_avail", 32'(bus.rx_avail), 32'(exp_rx.size() != 0));
      if (bus.rx_avail && bus.rx_take && exp_rx.size() != 0)
        chk("rx_pkt", bus.rx_pkt, exp_rx.pop_front());
      if (bus.put_inbound) begin
        if (exp_tx.size() != 0)
          chk("tx_byte", 32'(bus.payload_inbound), 32'(exp_tx.pop_front()));
        else
          chk("tx_spurious", 32'(bus.put_inbound), 32'(0));
      end else begin
        chk("tx_idle_payload", 32'(bus.payload_inbound), 32'(0));
      end
      if (rst_b && bus.tx_valid && bus.tx_ready)
        for (int k = 0; k < PKT_BYTES; k++)
          exp_tx.push_back(bus.tx_pkt[31-8*k -: 8]);
    end
  end

  task automatic send_rx(input pkt_t p, input int n, input logic tk);
    for (int k = 0; k < n; k++) begin
      cyc();
      bus.put_outbound = 1'b1;
      bus.payload_outbound = p[31-8*k -: 8];
      if (k == n - 1) bus.rx_take = tk;
      if (k == PKT_BYTES - 1) begin
        pend = 1'b1;
        pend_pkt = p;
      end
      @(negedge clk);
      chk("rx_free_byte", 32'(bus.free_outbound), 32'(k == 0));
    end
    cyc();
    bus.put_outbound = 1'b0;
    bus.payload_outbound = 8'h00;
    bus.rx_take = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst_b = 1'b0;
    bus.put_outbound = 1'b0;
    bus.tx_valid = 1'b0;
    bus.rx_take = 1'b0;
    cyc();
    rst_b = 1'b1;
    exp_rx.delete();
    exp_tx.delete();
    pend = 1'b0;
  endtask

  task automatic take_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      bus.rx_take = 1'b1;
    end
    cyc();
    bus.rx_take = 1'b0;
  endtask

  task automatic rx_node(input bit allow_start);
    if (rk != 0) begin
      bus.put_outbound = 1'b1;
      bus.payload_outbound = rp[31-8*rk -: 8];
      if (rk == PKT_BYTES - 1) begin
        pend = 1'b1;
        pend_pkt = rp;
        rk = 0;
      end else begin
        rk++;
      end
    end else if (allow_start && fprev && $urandom_range(3) != 0) begin
      rp = $urandom;
      bus.put_outbound = 1'b1;
      bus.payload_outbound = rp[31:24];
      rk = 1;
    end else begin
      bus.put_outbound = 1'b0;
      bus.payload_outbound = 8'($urandom);
    end
    fprev = bus.free_outbound;
  endtask

  initial begin
    bus.put_outbound = 1'b0;
    bus.payload_outbound = 8'h00;
    bus.free_inbound = 1'b0;
    bus.rx_take = 1'b0;
    bus.tx_pkt = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_free_out", 32'(bus.free_outbound), 32'(1));
    chk("rst_put_in", 32'(bus.put_inbound), 32'(0));
    chk("rst_payload_in", 32'(bus.payload_inbound), 32'(0));
    chk("rst_rx_pkt", bus.rx_pkt, 32'h0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'(1));
    chk("rst_proto_err", 32'(bus.proto_err), 32'(0));

    send_rx(32'hDEADBEEF, 4, 1'b0);
    @(negedge clk);
    chk("rx1_avail", 32'(bus.rx_avail), 32'(1));
    chk("rx1_pkt", bus.rx_pkt, 32'hDEADBEEF);
    take_n(1);
    @(negedge clk);
    chk("rx1_empty", 32'(bus.rx_avail), 32'(0));

    send_rx(32'h11223344, 4, 1'b0);
    send_rx(32'h55667788, 4, 1'b0);
    @(negedge clk);
    chk("full_free", 32'(bus.free_outbound), 32'(0));
    chk("full_head", bus.rx_pkt, 32'h11223344);
    chk("full_err0", 32'(bus.proto_err), 32'(0));
    cyc();
    bus.put_outbound = 1'b1;
    bus.payload_outbound = 8'h99;
    cyc();
    bus.put_outbound = 1'b0;
    @(negedge clk);
    chk("full_byte_err", 32'(bus.proto_err), 32'(1));
    chk("full_still", 32'(bus.free_outbound), 32'(0));
    take_n(1);
    @(negedge clk);
    chk("free_after_take", 32'(bus.free_outbound), 32'(1));
    chk("head_order", bus.rx_pkt, 32'h55667788);
    send_rx(32'h99AABBCC, 4, 1'b0);
    take_n(2);
    @(negedge clk);
    chk("wrap_empty", 32'(bus.rx_avail), 32'(0));

    send_rx(32'hA1A1A1A1, 4, 1'b1);
    @(negedge clk);
    chk("pop_empty_pkt", bus.rx_pkt, 32'hA1A1A1A1);
    send_rx(32'hB2B2B2B2, 4, 1'b1);
    @(negedge clk);
    chk("wp_c1_pkt", bus.rx_pkt, 32'hB2B2B2B2);
    chk("wp_c1_free", 32'(bus.free_outbound), 32'(1));
    send_rx(32'hC3C3C3C3, 4, 1'b0);
    @(negedge clk);
    chk("wp_c2_free", 32'(bus.free_outbound), 32'(0));
    take_n(2);

    cyc();
    bus.tx_pkt = 32'hCAFEF00D;
    bus.tx_valid = 1'b1;
    bus.free_inbound = 1'b1;
    @(negedge clk);
    chk("tx_ready_h", 32'(bus.tx_ready), 32'(1));
    cyc();
    bus.tx_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("tx_put_seq", 32'(bus.put_inbound), 32'(i >= 2 && i <= 5));
      chk("tx_ready_seq", 32'(bus.tx_ready), 32'(i == 7));
      if (i < 7) cyc();
    end
    cyc();
    bus.tx_pkt = 32'h12345678;
    bus.tx_valid = 1'b1;
    bus.free_inbound = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      bus.tx_valid = 1'b0;
      @(negedge clk);
      chk("tx_hold_put", 32'(bus.put_inbound), 32'(0));
    end
    cyc();
    bus.free_inbound = 1'b1;
    for (int i = 0; i < 12 && exp_tx.size() != 0; i++) cyc();
    chk("tx_hold_drain", 32'(exp_tx.size()), 32'(0));

    do_reset();
    @(negedge clk);
    chk("err_cleared", 32'(bus.proto_err), 32'(0));
    send_rx(32'h01020304, 2, 1'b0);
    cyc();
    @(negedge clk);
    chk("partial_err", 32'(bus.proto_err), 32'(1));
    chk("partial_nowr", 32'(bus.rx_avail), 32'(0));
    chk("partial_free", 32'(bus.free_outbound), 32'(1));

    cyc();
    bus.tx_pkt = 32'h13579BDF;
    bus.tx_valid = 1'b1;
    cyc();
    bus.tx_valid = 1'b0;
    cyc();
    cyc();
    bus.put_outbound = 1'b1;
    bus.payload_outbound = 8'h77;
    cyc();
    bus.put_outbound = 1'b0;
    rst_b = 1'b0;
    cyc();
    rst_b = 1'b1;
    exp_rx.delete();
    exp_tx.delete();
    pend = 1'b0;
    @(negedge clk);
    chk("mid_rst_put", 32'(bus.put_inbound), 32'(0));
    chk("mid_rst_avail", 32'(bus.rx_avail), 32'(0));
    chk("mid_rst_free", 32'(bus.free_outbound), 32'(1));
    chk("mid_rst_ready", 32'(bus.tx_ready), 32'(1));
    chk("mid_rst_err", 32'(bus.proto_err), 32'(0));

    fprev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      bus.rx_take = 1'($urandom);
      bus.tx_valid = 1'($urandom);
      bus.tx_pkt = $urandom;
      bus.free_inbound = 1'($urandom);
      rx_node(1'b1);
    end
    for (int c = 0; c < 60; c++) begin
      cyc();
      bus.rx_take = 1'b1;
      bus.free_inbound = 1'b1;
      bus.tx_valid = 1'b0;
      rx_node(1'b0);
      if (rk == 0 && !pend && exp_rx.size() == 0 &&
          exp_tx.size() == 0 && bus.tx_ready)
        break;
    end
    @(negedge clk);
    chk("drain_rx", 32'(exp_rx.size()), 32'(0));
    chk("drain_tx", 32'(exp_tx.size()), 32'(0));
    chk("rand_no_err", 32'(bus.proto_err), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_port.md
# router_port

Router-side endpoint of the byte-serial node link: the counterpart of each node's serializer/deserializer pair. It deserializes 4-byte packets arriving from a node into a small receive buffer for the router core, and serializes packets from the router core back to the node. One instance per router port; the node-facing wires keep the node's names (outbound = node→router, inbound = router→node).

## Interface
- `RX_DEPTH`, 2: receive buffer depth in packets (power of two, ≥2).
- `clk`  in  1  clock; all state changes on posedge.
- `rst_b`  in  1  synchronous, active-low reset.
- `put_outbound`  in  1  node is driving a valid byte on `payload_outbound`.
- `payload_outbound`  in  8  byte from node.
- `free_outbound`  out  1  router can accept a packet start; reset 1.
- `put_inbound`  out  1  router is driving a valid byte on `payload_inbound`; reset 0.
- `payload_inbound`  out  8  byte to node; 8'h00 when `put_inbound`=0; reset 8'h00.
- `free_inbound`  in  1  node can accept a packet start.
- `rx_pkt`  out  pkt_t  head of receive buffer; valid only when `rx_avail`; reset 0.
- `rx_avail`  out  1  receive buffer non-empty; reset 0.
- `rx_take`  in  1  core pops head this cycle (ignored when empty).
- `tx_pkt`  in  pkt_t  packet to send to node.
- `tx_valid`  in  1  core offers `tx_pkt`.
- `tx_ready`  out  1  transmitter idle; transfer when `tx_valid && tx_ready`; reset 1.
- `proto_err`  out  1  sticky: byte received while `free_outbound`=0 in R_IDLE; cleared only by reset; reset 0.

## Operation
- Link framing: a packet is exactly 4 bytes on 4 consecutive `put` cycles, MSB first (bits 31:24, 23:16, 15:8, 7:0). Sender may raise `put` no earlier than the cycle after it samples `free`=1.
- Receive FSM R_IDLE/R_RECV, 2-bit byte counter:
  - `free_outbound` = (R_IDLE && rx_count < RX_DEPTH); decoded from registers only.
  - R_IDLE, `put_outbound`=1, `free_outbound`=1: shift byte into assembly reg, cnt←1, → R_RECV.
  - R_RECV: each cycle shift byte (`asm <= {asm[23:0], payload}`), cnt+1; on 4th byte write assembled packet to buffer tail, → R_IDLE.
  - R_RECV with `put_outbound`=0 before 4 bytes: discard partial, set `proto_err`, → R_IDLE.
  - R_IDLE, `put_outbound`=1, `free_outbound`=0: byte ignored, `proto_err` set.
- Receive buffer: circular, RX_DEPTH entries, read/write pointers wrap modulo RX_DEPTH, count 0..RX_DEPTH. Same-cycle write and pop: count unchanged, both pointers advance (also when count=1 or count=RX_DEPTH). Pop on empty: no change.
- Transmit FSM T_IDLE/T_WAIT/T_SEND/T_GAP:
  - T_IDLE: `tx_ready`=1; on `tx_valid` latch `tx_pkt`, → T_WAIT.
  - T_WAIT: if `free_inbound`=1 → T_SEND, byte idx 0.
  - T_SEND: `put_inbound`=1, drive byte idx (MSB first); after idx 3 → T_GAP.
  - T_GAP: one cycle, `put_inbound`=0 (covers node's registered `free` lag), → T_IDLE.
- `free_inbound` is sampled only in T_WAIT; a drop during T_SEND does not abort.
- Receive and transmit paths are fully independent; concurrent operation allowed.

## Timing
- Rx: bytes at cycles t..t+3 (t in R_IDLE with free=1) → `free_outbound`=0 at t+1..t+3; packet at `rx_pkt` with `rx_avail`=1 at t+4 if buffer was empty; `free_outbound` at t+4 = room remaining.
- Back-to-back rx: node may restart at t+5 (sees free at t+4); sustained 1 packet / 5 cycles.
- Tx: handshake at cycle h → T_WAIT at h+1; if `free_inbound`=1 at w≥h+1, bytes at w+1..w+4, T_GAP w+5, `tx_ready` at w+6.
- Reset (`rst_b`=0 at a posedge): all FSMs idle, buffer emptied, partial packets discarded, all outputs to reset values from next cycle, even mid-packet.

## Structure
- Shared package: `pkt_t` (32-bit), link constants `PKT_BYTES`=4, state enums for both FSMs.
- One sub-module: `pkt_fifo` (parameterized circular buffer, sync reset, combinational head read). Rx/Tx FSMs live in `router_port`.

## Test plan
- Single rx: free seen, bytes DE,AD,BE,EF on 4 cycles → t+4 `rx_pkt`=32'hDEADBEEF, `rx_avail`=1; `rx_take` → `rx_avail`=0.
- Rx full: 2 packets (11223344, 55667788), no take → `free_outbound`=0; take one → free=1 next cycle; head order preserved; 3rd packet accepted, pointers wrap.
- Simultaneous write and pop with count=1 and count=2 → count unchanged, data order correct.
- Single tx: offer 32'hCAFEF00D, `free_inbound`=1 → bytes CA,FE,F0,0D on 4 consecutive cycles, gap cycle, `tx_ready` 6 cycles after WAIT entry; with `free_inbound` held 0 for 10 cycles → `put_inbound` stays 0.
- Protocol error: `put_outbound` for 2 cycles only, and a byte while free=0 → `proto_err`=1 sticky, no buffer write.
- Reset mid-tx after 2 bytes and mid-rx after 1 byte → next cycle `put_inbound`=0, `rx_avail`=0, `free_outbound`=1, `tx_ready`=1.
